idex_operand_stage: RTL and testbench

- ID/EX pipeline register plus operand-forwarding mux directly upstream of the ALU.
- Latches decoded instruction fields at the end of decode.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and builds the ALU's op1, op2, shamt and opcode.
- Also drives load-use stall detection back to the hazard unit and carries store data onward to MEM.

---
 rtl/idex_operand_stage.sv | 195 +++++++++++++++++++
 tb/tb_idex_operand_stage.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register with operand forwarding for the ALU.
// Captures decoded fields and resolves RAW hazards from EX/MEM and
// MEM/WB. Builds op1/op2/shamt/opcode and the store data, and raises
// a combinational load-use stall request toward the hazard unit.

package cpu_types_pkg;

   // ALU operation encoding. The all-zero code is SLL, so a cleared
   // latch shows up as ALU_SLL.
   typedef enum logic [3:0] {
      ALU_SLL  = 4'd0,
      ALU_SRL  = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_SUB  = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_NOR  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11
   } aluop_t;

   // Immediate extension modes. Code 11 behaves the same as 00.
   typedef enum logic [1:0] {
      EXT_ZERO  = 2'b00,
      EXT_SIGN  = 2'b01,
      EXT_UPPER = 2'b10,
      EXT_ZALT  = 2'b11
   } extop_t;

endpackage

module idex_operand_stage
   import cpu_types_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          en,
   input  logic          flush,
   input  logic          id_valid,
   input  aluop_t        id_aluop,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_wsel,
   input  logic [DW-1:0] id_rdat1,
   input  logic [DW-1:0] id_rdat2,
   input  logic [15:0]   id_imm16,
   input  logic [4:0]    id_shamt,
   input  logic [1:0]    id_extop,
   input  logic          id_alusrc,
   input  logic          id_regwen,
   input  logic          id_memread,
   input  logic          exm_regwen,
   input  logic          exm_memread,
   input  logic [RW-1:0] exm_wsel,
   input  logic [DW-1:0] exm_res,
   input  logic          wb_regwen,
   input  logic [RW-1:0] wb_wsel,
   input  logic [DW-1:0] wb_wdat,
   output logic [DW-1:0] op1,
   output logic [DW-1:0] op2,
   output logic [4:0]    shamt,
   output aluop_t        opcode,
   output logic          ex_valid,
   output logic          ex_regwen,
   output logic          ex_memread,
   output logic [RW-1:0] ex_wsel,
   output logic [DW-1:0] store_data,
   output logic          load_use_stall
);

   // Everything held across the ID/EX boundary. An all-zero value is
   // a bubble: not valid, no write-back, no load, opcode ALU_SLL.
   typedef struct packed {
      logic          valid;
      aluop_t        aluop;
      logic [RW-1:0] rs;
      logic [RW-1:0] rt;
      logic [RW-1:0] wsel;
      logic [DW-1:0] rdat1;
      logic [DW-1:0] rdat2;
      logic [15:0]   imm16;
      logic [4:0]    shamt;
      logic [1:0]    extop;
      logic          alusrc;
      logic          regwen;
      logic          memread;
   } idex_t;

   idex_t         q;
   idex_t         d_capture;
   logic [DW-1:0] fwd_rs;
   logic [DW-1:0] fwd_rt;
   logic [DW-1:0] imm_ext;
   logic          exm_fwd_ok;
   logic          rt_used;

   // A load still in EX/MEM has no data yet, so it never forwards.
   assign exm_fwd_ok = exm_regwen && !exm_memread;

   // Gather the decode-stage fields into one record for capture.
   always_comb begin
      // NOTE: every field gets a default first so no path leaves a latch behind.
      d_capture         = '0;
      d_capture.valid   = id_valid;
      d_capture.aluop   = id_aluop;
      d_capture.rs      = id_rs;
      d_capture.rt      = id_rt;
      d_capture.wsel    = id_wsel;
      d_capture.rdat1   = id_rdat1;
      d_capture.rdat2   = id_rdat2;
      d_capture.imm16   = id_imm16;
      d_capture.shamt   = id_shamt;
      d_capture.extop   = id_extop;
      d_capture.alusrc  = id_alusrc;
      d_capture.regwen  = id_regwen;
      d_capture.memread = id_memread;
   end

   // Pipeline latch: reset and flush load a bubble, en captures decode,
   // and a hold refreshes the operand copies with their forwarded values
   // so a producer retiring from WB during a stall is not lost.
   always_ff @(posedge CLK or posedge RST) begin
      // NOTE: non-blocking assignments make the update independent of statement order.
      if (RST) begin
         q <= '0;
      end else if (flush) begin
         q <= '0;
      end else if (en) begin
         q <= d_capture;
      end else begin
         q.rdat1 <= fwd_rs;
         q.rdat2 <= fwd_rt;
      end
   end

   // Forwarded rs value: EX/MEM beats MEM/WB, register 0 is never forwarded.
   always_comb begin
      fwd_rs = q.rdat1;
      if (q.rs != '0) begin
         if (exm_fwd_ok && (exm_wsel == q.rs)) begin
            fwd_rs = exm_res;
         end else if (wb_regwen && (wb_wsel == q.rs)) begin
            fwd_rs = wb_wdat;
         end
      end
   end

   // Forwarded rt value, same priority as rs.
   always_comb begin
      fwd_rt = q.rdat2;
      if (q.rt != '0) begin
         if (exm_fwd_ok && (exm_wsel == q.rt)) begin
            fwd_rt = exm_res;
         end else if (wb_regwen && (wb_wsel == q.rt)) begin
            fwd_rt = wb_wdat;
         end
      end
   end

   // Extend the latched immediate according to extop.
   always_comb begin
      imm_ext = {{(DW-16){1'b0}}, q.imm16};
      case (extop_t'(q.extop))
         EXT_SIGN:  imm_ext = {{(DW-16){q.imm16[15]}}, q.imm16};
         EXT_UPPER: imm_ext = {{(DW-16){1'b0}}, q.imm16} << 16;
         default:   imm_ext = {{(DW-16){1'b0}}, q.imm16};
      endcase
   end

   // ALU-facing operands; forwarding adds no cycle.
   assign op1        = fwd_rs;
   assign op2        = q.alusrc ? imm_ext : fwd_rt;
   assign store_data = fwd_rt;
   assign shamt      = q.shamt;
   assign opcode     = q.aluop;

   // Latched control carried on to EX.
   assign ex_valid   = q.valid;
   assign ex_regwen  = q.regwen;
   assign ex_memread = q.memread;
   assign ex_wsel    = q.wsel;

   // A load in EX whose destination the instruction in decode needs now.
   // rt only counts when decode will actually read it as an ALU operand.
   assign rt_used        = (q.wsel == id_rt) && !id_alusrc;
   assign load_use_stall = q.valid && q.memread && (q.wsel != '0) &&
                           ((q.wsel == id_rs) || rt_used);

endmodule

// File: tb/tb_idex_operand_stage.sv
// Directed testbench for idex_operand_stage: reset, immediate paths,
// forwarding priority, register 0, load-use stall, flush and hold.

module tb_idex_operand_stage;
   import cpu_types_pkg::*;

   localparam int DW = 32;
   localparam int RW = 5;

   logic          CLK;
   logic          RST;
   logic          en;
   logic          flush;
   logic          id_valid;
   aluop_t        id_aluop;
   logic [RW-1:0] id_rs;
   logic [RW-1:0] id_rt;
   logic [RW-1:0] id_wsel;
   logic [DW-1:0] id_rdat1;
   logic [DW-1:0] id_rdat2;
   logic [15:0]   id_imm16;
   logic [4:0]    id_shamt;
   logic [1:0]    id_extop;
   logic          id_alusrc;
   logic          id_regwen;
   logic          id_memread;
   logic          exm_regwen;
   logic          exm_memread;
   logic [RW-1:0] exm_wsel;
   logic [DW-1:0] exm_res;
   logic          wb_regwen;
   logic [RW-1:0] wb_wsel;
   logic [DW-1:0] wb_wdat;
   logic [DW-1:0] op1;
   logic [DW-1:0] op2;
   logic [4:0]    shamt;
   aluop_t        opcode;
   logic          ex_valid;
   logic          ex_regwen;
   logic          ex_memread;
   logic [RW-1:0] ex_wsel;
   logic [DW-1:0] store_data;
   logic          load_use_stall;

   int tests_run;
   int tests_failed;

   idex_operand_stage #(.DW(DW), .RW(RW)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .en             (en),
      .flush          (flush),
      .id_valid       (id_valid),
      .id_aluop       (id_aluop),
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .id_wsel        (id_wsel),
      .id_rdat1       (id_rdat1),
      .id_rdat2       (id_rdat2),
      .id_imm16       (id_imm16),
      .id_shamt       (id_shamt),
      .id_extop       (id_extop),
      .id_alusrc      (id_alusrc),
      .id_regwen      (id_regwen),
      .id_memread     (id_memread),
      .exm_regwen     (exm_regwen),
      .exm_memread    (exm_memread),
      .exm_wsel       (exm_wsel),
      .exm_res        (exm_res),
      .wb_regwen      (wb_regwen),
      .wb_wsel        (wb_wsel),
      .wb_wdat        (wb_wdat),
      .op1            (op1),
      .op2            (op2),
      .shamt          (shamt),
      .opcode         (opcode),
      .ex_valid       (ex_valid),
      .ex_regwen      (ex_regwen),
      .ex_memread     (ex_memread),
      .ex_wsel        (ex_wsel),
      .store_data     (store_data),
      .load_use_stall (load_use_stall)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic clear_inputs();
      en          = 1'b0;
      flush       = 1'b0;
      id_valid    = 1'b0;
      id_aluop    = ALU_SLL;
      id_rs       = '0;
      id_rt       = '0;
      id_wsel     = '0;
      id_rdat1    = '0;
      id_rdat2    = '0;
      id_imm16    = '0;
      id_shamt    = '0;
      id_extop    = 2'b00;
      id_alusrc   = 1'b0;
      id_regwen   = 1'b0;
      id_memread  = 1'b0;
      exm_regwen  = 1'b0;
      exm_memread = 1'b0;
      exm_wsel    = '0;
      exm_res     = '0;
      wb_regwen   = 1'b0;
      wb_wsel     = '0;
      wb_wdat     = '0;
   endtask

   // Capture the current id_* fields at the next rising edge, then return
   // 1 ns after it with en dropped.
   task automatic capture();
      en = 1'b1;
      @(posedge CLK);
      #1;
      en = 1'b0;
   endtask

   task automatic test_reset();
      // Load a full instruction, then hit RST mid-cycle.
      @(negedge CLK);
      id_valid = 1'b1; id_regwen = 1'b1; id_memread = 1'b1;
      id_aluop = ALU_ADD; id_rs = 5'd4; id_rt = 5'd7; id_wsel = 5'd9;
      id_rdat1 = 32'h1234; id_rdat2 = 32'h5678; id_shamt = 5'd3;
      capture();
      #2;
      RST = 1'b1;
      #1;
      tests_run++;
      if (op1 !== 32'h0 || op2 !== 32'h0 || store_data !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_operands: op1=%h op2=%h sd=%h expected all 0", op1, op2, store_data);
      end
      tests_run++;
      if (opcode !== ALU_SLL || shamt !== 5'd0 || ex_wsel !== 5'd0) begin
         tests_failed++;
         $display("FAIL reset_fields: opcode=%0d shamt=%0d wsel=%0d expected 0/0/0", opcode, shamt, ex_wsel);
      end
      tests_run++;
      if (ex_valid !== 1'b0 || ex_regwen !== 1'b0 || ex_memread !== 1'b0 || load_use_stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: valid=%b regwen=%b memread=%b stall=%b expected 0", ex_valid, ex_regwen, ex_memread, load_use_stall);
      end
      @(negedge CLK);
      RST = 1'b0;
      clear_inputs();
   endtask

   task automatic test_imm_ext();
      @(negedge CLK);
      id_valid = 1'b1; id_aluop = ALU_ADD; id_rs = 5'd1; id_rdat1 = 32'd5;
      id_imm16 = 16'hFFFC; id_extop = 2'b01; id_alusrc = 1'b1; id_shamt = 5'd17;
      capture();
      tests_run++;
      if (op1 !== 32'd5 || op2 !== 32'hFFFF_FFFC) begin
         tests_failed++;
         $display("FAIL imm_sign: op1=%h op2=%h expected 00000005 fffffffc", op1, op2);
      end
      tests_run++;
      if (opcode !== ALU_ADD || ex_valid !== 1'b1 || shamt !== 5'd17) begin
         tests_failed++;
         $display("FAIL imm_fields: opcode=%0d valid=%b shamt=%0d expected 2 1 17", opcode, ex_valid, shamt);
      end
      // Upper mode.
      id_imm16 = 16'h1234; id_extop = 2'b10;
      capture();
      tests_run++;
      if (op2 !== 32'h1234_0000) begin
         tests_failed++;
         $display("FAIL imm_upper: op2=%h expected 12340000", op2);
      end
      // Zero modes with the top bit set.
      id_imm16 = 16'h8001; id_extop = 2'b00;
      capture();
      tests_run++;
      if (op2 !== 32'h0000_8001) begin
         tests_failed++;
         $display("FAIL imm_zero00: op2=%h expected 00008001", op2);
      end
      id_extop = 2'b11;
      capture();
      tests_run++;
      if (op2 !== 32'h0000_8001) begin
         tests_failed++;
         $display("FAIL imm_zero11: op2=%h expected 00008001", op2);
      end
      clear_inputs();
   endtask

   task automatic test_forward_priority();
      @(negedge CLK);
      id_valid = 1'b1; id_rs = 5'd8; id_rt = 5'd8; id_alusrc = 1'b0;
      id_rdat1 = 32'hA; id_rdat2 = 32'hB;
      capture();
      exm_regwen = 1'b1; exm_memread = 1'b0; exm_wsel = 5'd8; exm_res = 32'h11;
      wb_regwen = 1'b1; wb_wsel = 5'd8; wb_wdat = 32'h22;
      #1;
      tests_run++;
      if (op1 !== 32'h11 || op2 !== 32'h11 || store_data !== 32'h11) begin
         tests_failed++;
         $display("FAIL fwd_exm: op1=%h op2=%h sd=%h expected 11", op1, op2, store_data);
      end
      exm_regwen = 1'b0;
      #1;
      tests_run++;
      if (op1 !== 32'h22 || op2 !== 32'h22 || store_data !== 32'h22) begin
         tests_failed++;
         $display("FAIL fwd_wb: op1=%h op2=%h sd=%h expected 22", op1, op2, store_data);
      end
      // A load in EX/MEM must not forward; WB still does.
      exm_regwen = 1'b1; exm_memread = 1'b1;
      #1;
      tests_run++;
      if (op1 !== 32'h22) begin
         tests_failed++;
         $display("FAIL fwd_exm_load: op1=%h expected 22", op1);
      end
      exm_regwen = 1'b0; exm_memread = 1'b0; wb_regwen = 1'b0;
      #1;
      tests_run++;
      if (op1 !== 32'hA || store_data !== 32'hB) begin
         tests_failed++;
         $display("FAIL fwd_none: op1=%h sd=%h expected a b", op1, store_data);
      end
      clear_inputs();
   endtask

   task automatic test_zero_reg();
      @(negedge CLK);
      id_valid = 1'b1; id_rs = 5'd0; id_rt = 5'd0; id_rdat1 = 32'h0; id_rdat2 = 32'h5;
      capture();
      exm_regwen = 1'b1; exm_wsel = 5'd0; exm_res = 32'hDEAD;
      wb_regwen = 1'b1; wb_wsel = 5'd0; wb_wdat = 32'hBEEF;
      #1;
      tests_run++;
      if (op1 !== 32'h0 || store_data !== 32'h5) begin
         tests_failed++;
         $display("FAIL zero_reg: op1=%h sd=%h expected 0 5", op1, store_data);
      end
      clear_inputs();
   endtask

   task automatic test_load_use();
      @(negedge CLK);
      id_valid = 1'b1; id_memread = 1'b1; id_regwen = 1'b1; id_wsel = 5'd3;
      capture();
      id_rs = 5'd3; id_rt = 5'd0; id_alusrc = 1'b0;
      #1;
      tests_run++;
      if (load_use_stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL lu_rs: stall=%b expected 1", load_use_stall);
      end
      id_rs = 5'd0; id_rt = 5'd3; id_alusrc = 1'b1;
      #1;
      tests_run++;
      if (load_use_stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL lu_rt_imm: stall=%b expected 0", load_use_stall);
      end
      id_alusrc = 1'b0;
      #1;
      tests_run++;
      if (load_use_stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL lu_rt: stall=%b expected 1", load_use_stall);
      end
      // Load targeting $0 never stalls.
      id_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
      capture();
      #1;
      tests_run++;
      if (load_use_stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL lu_wsel0: stall=%b expected 0", load_use_stall);
      end
      // Non-load producer never stalls.
      id_memread = 1'b0; id_wsel = 5'd3;
      capture();
      id_rs = 5'd3;
      #1;
      tests_run++;
      if (load_use_stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL lu_noload: stall=%b expected 0", load_use_stall);
      end
      clear_inputs();
   endtask

   task automatic test_flush_hold();
      @(negedge CLK);
      id_valid = 1'b1; id_regwen = 1'b1; id_wsel = 5'd4; id_aluop = ALU_OR;
      flush = 1'b1;
      capture();
      flush = 1'b0;
      tests_run++;
      if (ex_valid !== 1'b0 || ex_regwen !== 1'b0 || opcode !== ALU_SLL) begin
         tests_failed++;
         $display("FAIL flush_bubble: valid=%b regwen=%b opcode=%0d expected 0 0 0", ex_valid, ex_regwen, opcode);
      end
      // Real instruction reading $6, then stall two cycles.
      id_rs = 5'd6; id_rdat1 = 32'h5;
      capture();
      wb_regwen = 1'b1; wb_wsel = 5'd6; wb_wdat = 32'h77;
      @(posedge CLK);
      #1;
      wb_regwen = 1'b0; wb_wsel = 5'd0; wb_wdat = 32'h0;
      #1;
      tests_run++;
      if (op1 !== 32'h77) begin
         tests_failed++;
         $display("FAIL hold_keep1: op1=%h expected 77", op1);
      end
      @(posedge CLK);
      #1;
      tests_run++;
      if (op1 !== 32'h77 || ex_valid !== 1'b1 || opcode !== ALU_OR || ex_wsel !== 5'd4) begin
         tests_failed++;
         $display("FAIL hold_keep2: op1=%h valid=%b opcode=%0d wsel=%0d expected 77 1 5 4", op1, ex_valid, opcode, ex_wsel);
      end
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      @(negedge CLK);
      id_valid = 1'b1; id_aluop = ALU_XOR; id_rs = 5'd2; id_rdat1 = 32'h100; id_wsel = 5'd10;
      capture();
      tests_run++;
      if (op1 !== 32'h100 || opcode !== ALU_XOR || ex_wsel !== 5'd10) begin
         tests_failed++;
         $display("FAIL b2b_first: op1=%h opcode=%0d wsel=%0d expected 100 6 10", op1, opcode, ex_wsel);
      end
      id_aluop = ALU_SUB; id_rdat1 = 32'h200; id_wsel = 5'd11;
      capture();
      tests_run++;
      if (op1 !== 32'h200 || opcode !== ALU_SUB || ex_wsel !== 5'd11) begin
         tests_failed++;
         $display("FAIL b2b_second: op1=%h opcode=%0d wsel=%0d expected 200 3 11", op1, opcode, ex_wsel);
      end
      clear_inputs();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      clear_inputs();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #2;
      RST = 1'b0;

      test_reset();
      test_imm_ext();
      test_forward_priority();
      test_zero_reg();
      test_load_use();
      test_flush_hold();
      test_back_to_back();

      repeat (2) @(posedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
